// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and the ID/EX payload type used by the operand stage.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_src_e;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [REG_W-1:0]   rd;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
  } id_ex_t;

  // Upper-immediate and JAL formats carry immediate bits in the rs1 field.
  function automatic logic rs1_used(input logic [OPC_W-1:0] opc);
    return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  endfunction

  function automatic logic rs2_used(input logic [OPC_W-1:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand forwarding: picks the youngest producer of rs, falling back to reg-file data.
module id_fwd_mux
  import riscv_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic [REG_W-1:0]     rs,
  input  logic                 ex_en,
  input  logic [REG_W-1:0]     ex_wreg,
  input  logic [DataWidth-1:0] ex_wdata,
  input  logic                 mem_en,
  input  logic [REG_W-1:0]     mem_wreg,
  input  logic [DataWidth-1:0] mem_wdata,
  input  logic                 wb_en,
  input  logic [REG_W-1:0]     wb_wreg,
  input  logic [DataWidth-1:0] wb_wdata,
  input  logic [DataWidth-1:0] rf_data,
  output logic [DataWidth-1:0] data_c
);

  fwd_src_e src;

  // Youngest writer wins; WB is needed because the reg file reads stale data in the write cycle.
  always_comb begin
    src = FWD_RF;
    if (rs == '0)                           src = FWD_ZERO;
    else if (ex_en  && (ex_wreg  == rs))    src = FWD_EX;
    else if (mem_en && (mem_wreg == rs))    src = FWD_MEM;
    else if (wb_en  && (wb_wreg  == rs))    src = FWD_WB;
  end

  always_comb begin
    data_c = rf_data;
    case (src)
      FWD_ZERO: data_c = '0;
      FWD_EX:   data_c = ex_wdata;
      FWD_MEM:  data_c = mem_wdata;
      FWD_WB:   data_c = wb_wdata;
      default:  data_c = rf_data;
    endcase
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-read stage: reg-file read, forwarding, load-use stall and the ID/EX register.
module id_operand_stage
  import riscv_pkg::*;
#(
  parameter int unsigned          DataWidth = 32,
  parameter logic [DataWidth-1:0] ResetPc   = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_if_valid,
  input  logic [INSTR_W-1:0]   i_if_instr,
  input  logic [DataWidth-1:0] i_if_pc,
  output logic                 o_if_ready,
  output logic [REG_W-1:0]     o_rreg_0,
  output logic [REG_W-1:0]     o_rreg_1,
  input  logic [DataWidth-1:0] i_rdata_0,
  input  logic [DataWidth-1:0] i_rdata_1,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_we,
  input  logic                 i_ex_is_load,
  input  logic [REG_W-1:0]     i_ex_wreg,
  input  logic [DataWidth-1:0] i_ex_wdata,
  input  logic                 i_mem_valid,
  input  logic                 i_mem_we,
  input  logic [REG_W-1:0]     i_mem_wreg,
  input  logic [DataWidth-1:0] i_mem_wdata,
  input  logic                 i_wb_we,
  input  logic [REG_W-1:0]     i_wb_wreg,
  input  logic [DataWidth-1:0] i_wb_wdata,
  input  logic                 i_flush,
  output logic                 o_ex_valid,
  input  logic                 i_ex_ready,
  output logic [DataWidth-1:0] o_ex_pc,
  output logic [DataWidth-1:0] o_ex_rs1_data,
  output logic [DataWidth-1:0] o_ex_rs2_data,
  output logic [INSTR_W-1:0]   o_ex_instr,
  output logic [REG_W-1:0]     o_ex_rd,
  output logic [31:0]          o_stall_cnt
);

  logic [OPC_W-1:0]     opc;
  logic                 adv;
  logic                 hazard;
  logic                 ex_fwd_en;
  logic                 mem_fwd_en;
  logic [DataWidth-1:0] rs1_data;
  logic [DataWidth-1:0] rs2_data;
  id_ex_t               ex_q;
  id_ex_t               ex_d;

  assign opc      = i_if_instr[OPC_W-1:0];
  assign o_rreg_0 = i_if_instr[19:15];
  assign o_rreg_1 = i_if_instr[24:20];

  // A load in EX has no data yet, so it never forwards and instead stalls its consumers.
  assign ex_fwd_en  = i_ex_valid && i_ex_we && !i_ex_is_load;
  assign mem_fwd_en = i_mem_valid && i_mem_we;

  assign hazard = i_if_valid && i_ex_valid && i_ex_we && i_ex_is_load && (i_ex_wreg != '0)
               && ((rs1_used(opc) && (i_ex_wreg == o_rreg_0))
                || (rs2_used(opc) && (i_ex_wreg == o_rreg_1)));

  assign adv        = !o_ex_valid || i_ex_ready;
  assign o_if_ready = (adv && !hazard) || i_flush;

  id_fwd_mux #(.DataWidth(DataWidth)) u_fwd_rs1 (
    .rs(o_rreg_0),
    .ex_en(ex_fwd_en),   .ex_wreg(i_ex_wreg),   .ex_wdata(i_ex_wdata),
    .mem_en(mem_fwd_en), .mem_wreg(i_mem_wreg), .mem_wdata(i_mem_wdata),
    .wb_en(i_wb_we),     .wb_wreg(i_wb_wreg),   .wb_wdata(i_wb_wdata),
    .rf_data(i_rdata_0), .data_c(rs1_data)
  );

  id_fwd_mux #(.DataWidth(DataWidth)) u_fwd_rs2 (
    .rs(o_rreg_1),
    .ex_en(ex_fwd_en),   .ex_wreg(i_ex_wreg),   .ex_wdata(i_ex_wdata),
    .mem_en(mem_fwd_en), .mem_wreg(i_mem_wreg), .mem_wdata(i_mem_wdata),
    .wb_en(i_wb_we),     .wb_wreg(i_wb_wreg),   .wb_wdata(i_wb_wdata),
    .rf_data(i_rdata_1), .data_c(rs2_data)
  );

  always_comb begin
    ex_d          = ex_q;
    ex_d.pc       = XLEN'(i_if_pc);
    ex_d.instr    = i_if_instr;
    ex_d.rd       = i_if_instr[11:7];
    ex_d.rs1_data = XLEN'(rs1_data);
    ex_d.rs2_data = XLEN'(rs2_data);
  end

  // ID/EX register and bubble counter; flush overrides both hold and stall.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_ex_valid  <= 1'b0;
      ex_q        <= '{pc: XLEN'(ResetPc), default: '0};
      o_stall_cnt <= '0;
    end else if (i_flush) begin
      o_ex_valid <= 1'b0;
    end else if (adv) begin
      if (hazard) begin
        o_ex_valid <= 1'b0;
        if (o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 32'd1;
      end else begin
        o_ex_valid <= i_if_valid;
        if (i_if_valid) ex_q <= ex_d;
      end
    end
  end

  assign o_ex_pc       = DataWidth'(ex_q.pc);
  assign o_ex_instr    = ex_q.instr;
  assign o_ex_rd       = ex_q.rd;
  assign o_ex_rs1_data = DataWidth'(ex_q.rs1_data);
  assign o_ex_rs2_data = DataWidth'(ex_q.rs2_data);

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage with a cycle-level reference model and literal spot checks.
module tb_id_operand_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  localparam logic [31:0] I_ADDI_X1_X0_5  = 32'h0050_0093;
  localparam logic [31:0] I_ADDI_X4_X3_0  = 32'h0001_8213;
  localparam logic [31:0] I_ADD_X6_X5_X1  = 32'h0012_8333;
  localparam logic [31:0] I_LUI_X5_RS1F5  = 32'h0002_82B7;
  localparam logic [31:0] I_JAL_X1_RS1F5  = 32'h0002_80EF;
  localparam logic [31:0] I_ADDI_X7_X1_5  = 32'h0050_8393;
  localparam logic [31:0] I_SW_X5_0_X2    = 32'h0051_2023;

  logic        i_clk, i_rst;
  logic        i_if_valid;
  logic [31:0] i_if_instr, i_if_pc;
  logic        o_if_ready;
  logic [4:0]  o_rreg_0, o_rreg_1;
  logic [31:0] i_rdata_0, i_rdata_1;
  logic        i_ex_valid, i_ex_we, i_ex_is_load;
  logic [4:0]  i_ex_wreg;
  logic [31:0] i_ex_wdata;
  logic        i_mem_valid, i_mem_we;
  logic [4:0]  i_mem_wreg;
  logic [31:0] i_mem_wdata;
  logic        i_wb_we;
  logic [4:0]  i_wb_wreg;
  logic [31:0] i_wb_wdata;
  logic        i_flush;
  logic        o_ex_valid;
  logic        i_ex_ready;
  logic [31:0] o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_instr;
  logic [4:0]  o_ex_rd;
  logic [31:0] o_stall_cnt;

  logic [31:0] rf [32];
  assign i_rdata_0 = rf[o_rreg_0];
  assign i_rdata_1 = rf[o_rreg_1];

  id_operand_stage #(.DataWidth(32), .ResetPc(RESET_PC)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_valid(i_if_valid), .i_if_instr(i_if_instr), .i_if_pc(i_if_pc), .o_if_ready(o_if_ready),
    .o_rreg_0(o_rreg_0), .o_rreg_1(o_rreg_1), .i_rdata_0(i_rdata_0), .i_rdata_1(i_rdata_1),
    .i_ex_valid(i_ex_valid), .i_ex_we(i_ex_we), .i_ex_is_load(i_ex_is_load),
    .i_ex_wreg(i_ex_wreg), .i_ex_wdata(i_ex_wdata),
    .i_mem_valid(i_mem_valid), .i_mem_we(i_mem_we), .i_mem_wreg(i_mem_wreg), .i_mem_wdata(i_mem_wdata),
    .i_wb_we(i_wb_we), .i_wb_wreg(i_wb_wreg), .i_wb_wdata(i_wb_wdata),
    .i_flush(i_flush), .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready),
    .o_ex_pc(o_ex_pc), .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data),
    .o_ex_instr(o_ex_instr), .o_ex_rd(o_ex_rd), .o_stall_cnt(o_stall_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural rules evaluated on the current inputs.
  function automatic bit model_hazard();
    logic [6:0] opc = i_if_instr[6:0];
    bit reads1 = !(opc inside {7'b0110111, 7'b0010111, 7'b1101111});
    bit reads2 = opc inside {7'b0110011, 7'b0100011, 7'b1100011};
    bit ld     = i_ex_valid && i_ex_we && i_ex_is_load && (i_ex_wreg != 5'd0);
    return i_if_valid && ld && ((reads1 && (i_ex_wreg == i_if_instr[19:15]))
                             || (reads2 && (i_ex_wreg == i_if_instr[24:20])));
  endfunction

  function automatic logic [31:0] model_operand(input logic [4:0] rs);
    bit          hit [3];
    logic [31:0] val [3];
    hit[0] = i_ex_valid && i_ex_we && !i_ex_is_load && (i_ex_wreg == rs);  val[0] = i_ex_wdata;
    hit[1] = i_mem_valid && i_mem_we && (i_mem_wreg == rs);                val[1] = i_mem_wdata;
    hit[2] = i_wb_we && (i_wb_wreg == rs);                                 val[2] = i_wb_wdata;
    if (rs == 5'd0) return 32'd0;
    for (int k = 0; k < 3; k++) if (hit[k]) return val[k];
    return rf[rs];
  endfunction

  logic        m_valid;
  logic [31:0] m_pc, m_instr, m_rs1, m_rs2, m_cnt;
  logic [4:0]  m_rd;

  function automatic logic model_ready();
    return ((!m_valid || i_ex_ready) && !model_hazard()) || i_flush;
  endfunction

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      m_valid <= 1'b0; m_pc <= RESET_PC; m_instr <= '0; m_rd <= '0;
      m_rs1 <= '0; m_rs2 <= '0; m_cnt <= '0;
    end else if (i_flush) begin
      m_valid <= 1'b0;
    end else if (!m_valid || i_ex_ready) begin
      if (model_hazard()) begin
        m_valid <= 1'b0;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
      end else begin
        m_valid <= i_if_valid;
        if (i_if_valid) begin
          m_pc    <= i_if_pc;
          m_instr <= i_if_instr;
          m_rd    <= i_if_instr[11:7];
          m_rs1   <= model_operand(i_if_instr[19:15]);
          m_rs2   <= model_operand(i_if_instr[24:20]);
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (started && i_rst) begin
      chk("ex_valid", 32'(o_ex_valid), 32'(m_valid));
      chk("stall_cnt", o_stall_cnt, m_cnt);
      chk("if_ready", 32'(o_if_ready), 32'(model_ready()));
      chk("rreg_0", 32'(o_rreg_0), 32'(i_if_instr[19:15]));
      chk("rreg_1", 32'(o_rreg_1), 32'(i_if_instr[24:20]));
      if (m_valid) begin
        chk("ex_pc", o_ex_pc, m_pc);
        chk("ex_instr", o_ex_instr, m_instr);
        chk("ex_rd", 32'(o_ex_rd), 32'(m_rd));
        chk("ex_rs1", o_ex_rs1_data, m_rs1);
        chk("ex_rs2", o_ex_rs2_data, m_rs2);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic clear_producers();
    i_ex_valid = 0; i_ex_we = 0; i_ex_is_load = 0; i_ex_wreg = '0; i_ex_wdata = '0;
    i_mem_valid = 0; i_mem_we = 0; i_mem_wreg = '0; i_mem_wdata = '0;
    i_wb_we = 0; i_wb_wreg = '0; i_wb_wdata = '0;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    i_ex_valid = 1; i_ex_we = 1; i_ex_is_load = 1; i_ex_wreg = rd; i_ex_wdata = 32'hDEAD_BEEF;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
    i_if_valid = 1; i_if_instr = instr; i_if_pc = pc;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 32'hA000_0000 + 32'(r);
    rf[0] = '0; rf[1] = 32'h0000_1111; rf[3] = 32'd7;
    i_rst = 0; i_if_valid = 0; i_if_instr = '0; i_if_pc = '0;
    i_flush = 0; i_ex_ready = 1;
    clear_producers();

    repeat (2) @(posedge i_clk);
    #2;
    chk("rst_valid", 32'(o_ex_valid), 32'd0);
    chk("rst_pc", o_ex_pc, RESET_PC);
    chk("rst_cnt", o_stall_cnt, 32'd0);
    chk("rst_instr", o_ex_instr, 32'd0);
    i_rst = 1;
    started = 1;

    // addi x1,x0,5: no dependency
    fetch(I_ADDI_X1_X0_5, 32'h200);
    step();
    chk("nodep_valid", 32'(o_ex_valid), 32'd1);
    chk("nodep_rs1", o_ex_rs1_data, 32'd0);
    chk("nodep_rd", 32'(o_ex_rd), 32'd1);
    chk("nodep_ready", 32'(o_if_ready), 32'd1);

    // forwarding priority on rs1=x3
    fetch(I_ADDI_X4_X3_0, 32'h204);
    i_wb_we = 1; i_wb_wreg = 5'd3; i_wb_wdata = 32'd9;
    i_mem_valid = 1; i_mem_we = 1; i_mem_wreg = 5'd3; i_mem_wdata = 32'd11;
    i_ex_valid = 1; i_ex_we = 1; i_ex_wreg = 5'd3; i_ex_wdata = 32'd13;
    step(); chk("prio_ex", o_ex_rs1_data, 32'd13);
    i_ex_valid = 0;
    step(); chk("prio_mem", o_ex_rs1_data, 32'd11);
    i_mem_valid = 0;
    step(); chk("prio_wb", o_ex_rs1_data, 32'd9);
    i_wb_we = 0;
    step(); chk("prio_rf", o_ex_rs1_data, 32'd7);
    clear_producers();

    // load-use on rs1, resolved by MEM forwarding
    ex_load(5'd5);
    fetch(I_ADD_X6_X5_X1, 32'h300);
    #1 chk("lu_ready", 32'(o_if_ready), 32'd0);
    step();
    chk("lu_bubble", 32'(o_ex_valid), 32'd0);
    chk("lu_cnt", o_stall_cnt, 32'd1);
    clear_producers();
    i_mem_valid = 1; i_mem_we = 1; i_mem_wreg = 5'd5; i_mem_wdata = 32'h55;
    #1 chk("lu_ready2", 32'(o_if_ready), 32'd1);
    step();
    chk("lu_issue", 32'(o_ex_valid), 32'd1);
    chk("lu_rs1", o_ex_rs1_data, 32'h55);
    chk("lu_rs2", o_ex_rs2_data, 32'h1111);
    chk("lu_rd", 32'(o_ex_rd), 32'd6);
    clear_producers();

    // field match without a real use must not stall
    ex_load(5'd5);
    fetch(I_LUI_X5_RS1F5, 32'h310);
    #1 chk("lui_ready", 32'(o_if_ready), 32'd1);
    step();
    fetch(I_JAL_X1_RS1F5, 32'h314);
    step();
    chk("jal_cnt", o_stall_cnt, 32'd1);
    chk("jal_pc", o_ex_pc, 32'h314);
    fetch(I_ADDI_X7_X1_5, 32'h318);
    step();
    chk("addi_rs2f_cnt", o_stall_cnt, 32'd1);
    // store reads rs2 for real
    fetch(I_SW_X5_0_X2, 32'h31C);
    step();
    chk("sw_cnt", o_stall_cnt, 32'd2);
    clear_producers();
    step();

    // backpressure: hold payload, then flush during the hold
    fetch(I_ADDI_X1_X0_5, 32'h400);
    step();
    i_ex_ready = 0;
    fetch(I_ADDI_X4_X3_0, 32'h404);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_pc", o_ex_pc, 32'h400);
      chk("bp_ready", 32'(o_if_ready), 32'd0);
    end
    i_flush = 1;
    step();
    chk("bp_flush", 32'(o_ex_valid), 32'd0);
    i_flush = 0; i_ex_ready = 1; i_if_valid = 0;
    step();

    // flush and hazard together: flush wins, counter unchanged
    ex_load(5'd5);
    fetch(I_ADD_X6_X5_X1, 32'h500);
    i_flush = 1;
    step();
    chk("fh_valid", 32'(o_ex_valid), 32'd0);
    chk("fh_cnt", o_stall_cnt, 32'd2);
    i_flush = 0;

    // async reset in the middle of a stall
    step();
    chk("pre_rst_cnt", o_stall_cnt, 32'd3);
    #1 i_rst = 0;
    #1;
    chk("arst_valid", 32'(o_ex_valid), 32'd0);
    chk("arst_cnt", o_stall_cnt, 32'd0);
    chk("arst_pc", o_ex_pc, RESET_PC);
    step();
    i_rst = 1;
    clear_producers();
    fetch(I_ADD_X6_X5_X1, 32'h600);
    step();
    chk("post_rst_rs1", o_ex_rs1_data, 32'hA000_0005);
    i_if_valid = 0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
